// File: rtl/vdg_pkg.sv
// Shared constants and types for the VDG fetch responder: mode encodings,
// row geometry constants and the fetch FSM states.
package vdg_pkg;

  localparam int PAGE_SHIFT = 9;

  localparam logic [5:0] ROW_W16 = 6'd16;
  localparam logic [5:0] ROW_W32 = 6'd32;

  localparam logic [3:0] REP_1  = 4'd1;
  localparam logic [3:0] REP_2  = 4'd2;
  localparam logic [3:0] REP_3  = 4'd3;
  localparam logic [3:0] REP_12 = 4'd12;

  typedef enum logic [2:0] {
    GM0 = 3'd0, GM1 = 3'd1, GM2 = 3'd2, GM3 = 3'd3,
    GM4 = 3'd4, GM5 = 3'd5, GM6 = 3'd6, GM7 = 3'd7
  } gm_e;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} fetch_state_e;

  typedef struct packed {
    logic [5:0] bpr;
    logic [3:0] rep;
  } geom_t;

  localparam geom_t GEOM_ALPHA = '{bpr: ROW_W32, rep: REP_12};

endpackage

// File: rtl/vdg_fetch_responder_if.sv
// RAM arbiter read port: the responder drives request/address, the arbiter
// returns a one-cycle acknowledge with data in the same cycle.
interface vdg_fetch_responder_if #(parameter int ADDR_W = 16);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/vdg_row_geometry.sv
// Combinational decode of the VDG mode into bytes per row and row repeat count.
module vdg_row_geometry
  import vdg_pkg::*;
(
  input  logic       ang,
  input  logic [2:0] gm,
  output geom_t      geom
);

  always_comb begin
    geom = GEOM_ALPHA;
    if (ang) begin
      case (gm_e'(gm))
        GM0, GM1: geom = '{bpr: ROW_W16, rep: REP_3};
        GM2:      geom = '{bpr: ROW_W32, rep: REP_3};
        GM3:      geom = '{bpr: ROW_W16, rep: REP_2};
        GM4:      geom = '{bpr: ROW_W32, rep: REP_2};
        GM5:      geom = '{bpr: ROW_W16, rep: REP_1};
        default:  geom = '{bpr: ROW_W32, rep: REP_1};
      endcase
    end
  end

endmodule

// File: rtl/vdg_fetch_responder.sv
// Memory-side responder for VDG byte fetches: sync tracking, display address
// generation, and a single-outstanding RAM read with one queued fetch.
module vdg_fetch_responder
  import vdg_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int BASE_W = 7
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fsn,
  input  logic                   hsn,
  input  logic                   da_req,
  input  logic                   ang,
  input  logic [2:0]             gm,
  input  logic [BASE_W-1:0]      base,
  vdg_fetch_responder_if.master  mem,
  output logic [7:0]             q,
  output logic                   q_valid,
  output logic                   overrun
);

  logic              r_fsn_d, r_hsn_d;
  logic              w_fsn_fall, w_hsn_fall;
  geom_t             w_geom_dec, r_geom, w_geom_n;
  logic [ADDR_W-1:0] r_row_start, w_row_n;
  logic [5:0]        r_byte_idx, w_bidx_n;
  logic [3:0]        r_rep, w_rep_n;
  logic [ADDR_W-1:0] w_base_addr, w_fetch_addr;
  logic              w_acc, w_q_live;

  fetch_state_e      r_state;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_q_vld;
  logic [ADDR_W-1:0] r_q_addr;
  logic [7:0]        r_q;
  logic              r_q_valid;
  logic              r_overrun;

  vdg_row_geometry u_geom (
    .ang  (ang),
    .gm   (gm),
    .geom (w_geom_dec)
  );

  assign w_fsn_fall  = r_fsn_d & ~fsn;
  assign w_hsn_fall  = r_hsn_d & ~hsn;
  assign w_base_addr = ADDR_W'(base) << PAGE_SHIFT;

  // Sync updates resolve first so a coincident fetch sees the new row and byte 0
  always_comb begin
    w_row_n  = r_row_start;
    w_bidx_n = r_byte_idx;
    w_rep_n  = r_rep;
    w_geom_n = r_geom;
    if (w_fsn_fall) begin
      w_row_n  = w_base_addr;
      w_bidx_n = '0;
      w_rep_n  = '0;
      w_geom_n = w_geom_dec;
    end else if (w_hsn_fall) begin
      w_bidx_n = '0;
      w_geom_n = w_geom_dec;
      if (r_rep == r_geom.rep - 4'd1) begin
        w_row_n = r_row_start + ADDR_W'(r_geom.bpr);
        w_rep_n = '0;
      end else begin
        w_rep_n = r_rep + 4'd1;
      end
    end
  end

  // Requests past the row end come from the border and are silently ignored
  assign w_acc        = da_req && (w_bidx_n < w_geom_n.bpr);
  assign w_fetch_addr = w_row_n + ADDR_W'(w_bidx_n);
  assign w_q_live     = r_q_vld & ~w_fsn_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsn_d     <= 1'b1;
      r_hsn_d     <= 1'b1;
      r_row_start <= '0;
      r_byte_idx  <= '0;
      r_rep       <= '0;
      r_geom      <= GEOM_ALPHA;
    end else begin
      r_fsn_d     <= fsn;
      r_hsn_d     <= hsn;
      r_row_start <= w_row_n;
      r_byte_idx  <= w_bidx_n + {5'b0, w_acc};
      r_rep       <= w_rep_n;
      r_geom      <= w_geom_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_q_vld    <= 1'b0;
      r_q_addr   <= '0;
      r_q        <= '0;
      r_q_valid  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_q_valid <= 1'b0;
      if (w_fsn_fall) r_overrun <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_q_vld <= 1'b0;
          if (w_acc) begin
            r_state    <= REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_fetch_addr;
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            r_q       <= mem.mem_rdata;
            r_q_valid <= 1'b1;
            if (w_q_live) begin
              // Queued fetch goes out next; the freed slot may take a new one
              r_mem_addr <= r_q_addr;
              r_q_vld    <= w_acc;
              if (w_acc) r_q_addr <= w_fetch_addr;
            end else if (w_acc) begin
              r_mem_addr <= w_fetch_addr;
              r_q_vld    <= 1'b0;
            end else begin
              r_state   <= IDLE;
              r_mem_req <= 1'b0;
              r_q_vld   <= 1'b0;
            end
          end else if (w_acc && !w_q_live) begin
            r_q_vld  <= 1'b1;
            r_q_addr <= w_fetch_addr;
          end else if (w_acc) begin
            r_overrun <= 1'b1;
          end else begin
            r_q_vld <= w_q_live;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem.mem_req  = r_mem_req;
  assign mem.mem_addr = r_mem_addr;
  assign q            = r_q;
  assign q_valid      = r_q_valid;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_vdg_fetch_responder.sv
// Bench for vdg_fetch_responder: directed mode scenarios plus randomized traffic
// checked every cycle against a queue-based behavioural model.
module tb_vdg_fetch_responder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       fsn, hsn, da_req, ang;
  logic [2:0] gm;
  logic [6:0] base;
  logic [7:0] q;
  logic       q_valid, overrun;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vdg_fetch_responder_if #(.ADDR_W(16)) mif ();

  vdg_fetch_responder #(.ADDR_W(16), .BASE_W(7)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .fsn     (fsn),
    .hsn     (hsn),
    .da_req  (da_req),
    .ang     (ang),
    .gm      (gm),
    .base    (base),
    .mem     (mif),
    .q       (q),
    .q_valid (q_valid),
    .overrun (overrun)
  );

  // Reference model state: pend[0] is the fetch being served, pend[1] the queued one
  logic [15:0] m_row;
  int          m_bidx;
  logic [3:0]  m_rep;
  int          m_bpr, m_repn;
  logic        m_pf, m_ph;
  logic [15:0] pend[$];
  logic [7:0]  m_q;
  logic        m_qv, m_ovr;
  logic [15:0] seen[$];

  task automatic geom(input logic a, input logic [2:0] g, output int bpr, output int rp);
    if (!a) begin bpr = 32; rp = 12; end
    else begin
      case (g)
        3'd0, 3'd1: begin bpr = 16; rp = 3; end
        3'd2:       begin bpr = 32; rp = 3; end
        3'd3:       begin bpr = 16; rp = 2; end
        3'd4:       begin bpr = 32; rp = 2; end
        3'd5:       begin bpr = 16; rp = 1; end
        default:    begin bpr = 32; rp = 1; end
      endcase
    end
  endtask

  task automatic model_reset();
    m_row = 16'h0; m_bidx = 0; m_rep = 4'd0; m_bpr = 32; m_repn = 12;
    m_pf = 1'b1; m_ph = 1'b1; pend.delete(); m_q = 8'h0; m_qv = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, advance the model, check #1 after posedge
  task automatic cyc(input logic f, input logic h, input logic d, input logic k);
    int  nb, nr;
    logic ff, hf;
    fsn = f; hsn = h; da_req = d;
    mif.mem_ack = k; mif.mem_rdata = 8'($urandom);
    if (k && mif.mem_req) seen.push_back(mif.mem_addr);
    ff = m_pf & ~f; hf = m_ph & ~h; m_pf = f; m_ph = h; m_qv = 1'b0;
    if (ff && pend.size() > 1) pend.delete(1);
    if (k && pend.size() > 0) begin m_q = mif.mem_rdata; m_qv = 1'b1; pend.delete(0); end
    geom(ang, gm, nb, nr);
    if (ff) begin
      m_row = {base, 9'b0}; m_bidx = 0; m_rep = 4'd0; m_bpr = nb; m_repn = nr; m_ovr = 1'b0;
    end else if (hf) begin
      m_bidx = 0;
      if (int'(m_rep) == m_repn - 1) begin m_row = m_row + 16'(m_bpr); m_rep = 4'd0; end
      else m_rep = m_rep + 4'd1;
      m_bpr = nb; m_repn = nr;
    end
    if (d && m_bidx < m_bpr) begin
      if (pend.size() < 2) pend.push_back(m_row + 16'(m_bidx));
      else m_ovr = 1'b1;
      m_bidx++;
    end
    @(posedge clk); #1;
    chk("mem_req", {31'b0, mif.mem_req}, {31'b0, pend.size() > 0});
    if (pend.size() > 0) chk("mem_addr", {16'b0, mif.mem_addr}, {16'b0, pend[0]});
    chk("q_valid", {31'b0, q_valid}, {31'b0, m_qv});
    chk("q", {24'b0, q}, {24'b0, m_q});
    chk("overrun", {31'b0, overrun}, {31'b0, m_ovr});
    @(negedge clk);
  endtask

  task automatic fpulse(input logic k);
    cyc(1'b0, 1'b1, 1'b0, k); cyc(1'b1, 1'b1, 1'b0, k);
  endtask

  task automatic hpulse(input logic k);
    cyc(1'b1, 1'b0, 1'b0, k); cyc(1'b1, 1'b1, 1'b0, k);
  endtask

  initial begin
    reset_n = 1'b0; fsn = 1'b1; hsn = 1'b1; da_req = 1'b0;
    ang = 1'b0; gm = 3'd0; base = 7'h0; mif.mem_ack = 1'b0; mif.mem_rdata = 8'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'b0, mif.mem_req}, 32'd0);
    chk("rst_mem_addr", {16'b0, mif.mem_addr}, 32'd0);
    chk("rst_q", {24'b0, q}, 32'd0);
    chk("rst_q_valid", {31'b0, q_valid}, 32'd0);
    chk("rst_overrun", {31'b0, overrun}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // GM6 at base page 2, zero-wait ack: two lines of 32 bytes
    ang = 1'b1; gm = 3'd6; base = 7'h02;
    fpulse(1'b1);
    seen.delete();
    for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    hpulse(1'b1);
    for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("gm6_count", seen.size(), 32'd64);
    for (int i = 0; i < 64; i++)
      if (i < seen.size()) chk("gm6_addr", {16'b0, seen[i]}, 32'h0400 + i);

    // Alpha: twelve repeated lines, thirteenth advances one row
    ang = 1'b0; base = 7'h00;
    fpulse(1'b1);
    seen.delete();
    for (int l = 0; l < 13; l++) begin
      for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1);
      repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b1);
      hpulse(1'b1);
    end
    chk("alpha_count", seen.size(), 32'd416);
    for (int i = 0; i < 416; i++)
      if (i < seen.size()) chk("alpha_addr", {16'b0, seen[i]}, (i >= 384) ? 32'h20 + (i % 32) : (i % 32));

    // GM1: over-requesting border is ignored without overrun
    ang = 1'b1; gm = 3'd1;
    fpulse(1'b1);
    seen.delete();
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("gm1_count", seen.size(), 32'd16);
    if (seen.size() > 0) chk("gm1_last", {16'b0, seen[seen.size()-1]}, 32'h000F);
    chk("gm1_overrun", {31'b0, overrun}, 32'd0);

    // Slow ack: third back-to-back fetch is dropped
    fpulse(1'b0);
    seen.delete();
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("slow_count", seen.size(), 32'd2);
    if (seen.size() == 2) begin
      chk("slow_first", {16'b0, seen[0]}, 32'h0000);
      chk("slow_second", {16'b0, seen[1]}, 32'h0001);
    end
    chk("slow_overrun_set", {31'b0, overrun}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("slow_overrun_clr", {31'b0, overrun}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);

    // GM7 at the top page: row addresses wrap through 0xFFE0 to 0x0000
    ang = 1'b1; gm = 3'd7; base = 7'h7F;
    fpulse(1'b1);
    seen.delete();
    for (int r = 0; r < 17; r++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      hpulse(1'b1);
    end
    chk("wrap_count", seen.size(), 32'd17);
    for (int r = 0; r < 17; r++)
      if (r < seen.size()) chk("wrap_addr", {16'b0, seen[r]}, {16'b0, 16'(16'hFE00 + 32 * r)});
    seen.delete();
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("coinc_count", seen.size(), 32'd1);
    if (seen.size() > 0) chk("coinc_addr", {16'b0, seen[0]}, 32'hFE00);

    // Randomized traffic; mode and base change only with a frame sync
    for (int c = 0; c < 4000; c++) begin
      logic f, h;
      f = ($urandom_range(0, 299) != 0);
      h = ($urandom_range(0, 39) != 0);
      if (!f) begin ang = 1'($urandom); gm = 3'($urandom); base = 7'($urandom); end
      cyc(f, h, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
    end

    // Asynchronous reset during an outstanding request
    fpulse(1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("pre_rst_req", {31'b0, mif.mem_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_mem_req", {31'b0, mif.mem_req}, 32'd0);
    chk("arst_mem_addr", {16'b0, mif.mem_addr}, 32'd0);
    chk("arst_q", {24'b0, q}, 32'd0);
    chk("arst_q_valid", {31'b0, q_valid}, 32'd0);
    chk("arst_overrun", {31'b0, overrun}, 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
